// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared sizes and loader state encoding
package program_loader_pkg;
  localparam int PL_WORD_SIZE = 16;
  localparam int PL_MEM_ADDR_SIZE = 8;
  typedef enum logic [3:0] {
    LDR_IDLE,
    LDR_LEN_HI,
    LDR_LEN_LO,
    LDR_DATA_HI,
    LDR_DATA_LO,
    LDR_WRITE,
    LDR_START,
    LDR_RUN,
    LDR_HALTED,
    LDR_ERROR
  } ldr_state_e;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: valid/ready byte stream feeding the loader
interface program_loader_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, in_valid, input in_ready);
  modport slave(input in_data, in_valid, output in_ready);
endinterface

// File: rtl/program_loader_word_assembler.sv
// program_loader_word_assembler: packs a big-endian byte pair into one word
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    hi_en,
  input  logic                    lo_en,
  input  logic [7:0]              byte_in,
  output logic [PL_WORD_SIZE-1:0] word
);
  logic [PL_WORD_SIZE-1:0] word_q, word_d;
  always_comb
    word_d = hi_en ? {byte_in, word_q[7:0]} : lo_en ? {word_q[15:8], byte_in} : word_q;
  always_ff @(posedge clock)
    if (!reset) word_q <= '0;
    else word_q <= word_d;
  assign word = word_q;
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed program into memory, then runs the cpu until halt
module program_loader
  import program_loader_pkg::*;
#(
  parameter int WORD_SIZE     = PL_WORD_SIZE,
  parameter int MEM_ADDR_SIZE = PL_MEM_ADDR_SIZE
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  program_loader_if.slave          stream,
  output logic                     cpu_reset,
  output logic                     cpu_execute,
  input  logic                     cpu_halted,
  input  logic [MEM_ADDR_SIZE-1:0] cpu_mem_address,
  input  logic [WORD_SIZE-1:0]     cpu_mem_wdata,
  input  logic                     cpu_mem_read,
  input  logic                     cpu_mem_write,
  output logic [MEM_ADDR_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0]     mem_write_data,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);
  localparam int MAX_LEN = 2 ** MEM_ADDR_SIZE;
  ldr_state_e state_q, state_d;
  logic [15:0] len_q, len_d, len_full;
  logic [MEM_ADDR_SIZE:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] word;
  logic take, run, wr;
  assign stream.in_ready = state_q inside {LDR_LEN_HI, LDR_LEN_LO, LDR_DATA_HI, LDR_DATA_LO};
  assign take = stream.in_valid & stream.in_ready;
  assign len_full = {len_q[15:8], stream.in_data};
  program_loader_word_assembler u_asm (
    .clock  (clock),
    .reset  (reset),
    .hi_en  (take && state_q == LDR_DATA_HI),
    .lo_en  (take && state_q == LDR_DATA_LO),
    .byte_in(stream.in_data),
    .word   (word)
  );
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    addr_d = addr_q;
    case (state_q)
      LDR_IDLE, LDR_HALTED: if (start) begin
        state_d = LDR_LEN_HI;
        addr_d = '0;
      end
      LDR_LEN_HI: if (take) begin
        len_d = {stream.in_data, 8'h00};
        state_d = LDR_LEN_LO;
      end
      LDR_LEN_LO: if (take) begin
        len_d = len_full;
        state_d = len_full == 16'd0 ? LDR_START : int'(len_full) > MAX_LEN ? LDR_ERROR : LDR_DATA_HI;
      end
      LDR_DATA_HI: if (take) state_d = LDR_DATA_LO;
      LDR_DATA_LO: if (take) state_d = LDR_WRITE;
      LDR_WRITE: begin
        addr_d = addr_q + 1'b1;
        state_d = 16'(addr_d) == len_q ? LDR_START : LDR_DATA_HI;
      end
      LDR_START: state_d = LDR_RUN;
      LDR_RUN: if (cpu_halted) state_d = LDR_HALTED;
      default: ;
    endcase
  end
  always_ff @(posedge clock)
    if (!reset) begin
      state_q <= LDR_IDLE;
      len_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      addr_q <= addr_d;
    end
  // the cpu owns the memory port only while running; the loader drives it only in WRITE
  assign run = state_q == LDR_RUN;
  assign wr = state_q == LDR_WRITE;
  assign cpu_reset = !(run || state_q == LDR_HALTED);
  assign cpu_execute = run;
  assign mem_read = run & cpu_mem_read;
  assign mem_write = run ? cpu_mem_write : wr;
  assign mem_address = run ? cpu_mem_address : wr ? addr_q[MEM_ADDR_SIZE-1:0] : '0;
  assign mem_write_data = run ? cpu_mem_wdata : wr ? word : '0;
  assign busy = state_q inside {LDR_LEN_HI, LDR_LEN_LO, LDR_DATA_HI, LDR_DATA_LO, LDR_WRITE, LDR_START};
  assign done = state_q == LDR_HALTED;
  assign error = state_q == LDR_ERROR;
endmodule
